// File: rtl/gate_sweep_ctrl.sv
// Applies the four input vectors to a 2-input XOR gate under test, checks y, reports pass/err_cnt.
// Optional SWEEP_ERR_HALT_EN: stop the sweep at the first mismatching vector.
module gate_sweep_ctrl #(
  parameter int HOLD = 5,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_cnt,
  output logic [1:0] vec_idx
);

  typedef enum logic [1:0] {IDLE, APPLY, DONE} state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(HOLD - 1);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [1:0]    vec_next;
  logic [2:0]    err_next;
  logic          pass_next;
  logic          mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      vec_idx <= 2'd0;
      err_cnt <= 3'd0;
      pass    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      vec_idx <= vec_next;
      err_cnt <= err_next;
      pass    <= pass_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    vec_next   = vec_idx;
    err_next   = err_cnt;
    pass_next  = pass;
    mismatch   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = APPLY;
          cnt_next   = '0;
          vec_next   = 2'd0;
          err_next   = 3'd0;
        end
      end
      APPLY: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          // {a,b} equals vec_idx here, so the reference is the XOR of its bits
          mismatch = y != (vec_idx[1] ^ vec_idx[0]);
          err_next = err_cnt + {2'b00, mismatch};
          cnt_next = '0;
`ifdef SWEEP_ERR_HALT_EN
          if (mismatch) begin
            state_next = DONE;
            pass_next  = 1'b0;
          end else if (vec_idx == 2'd3) begin
            state_next = DONE;
            pass_next  = (err_next == 3'd0);
          end else begin
            vec_next = vec_idx + 2'd1;
          end
`else
          if (vec_idx == 2'd3) begin
            state_next = DONE;
            pass_next  = (err_next == 3'd0);
          end else begin
            vec_next = vec_idx + 2'd1;
          end
`endif
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == APPLY);
  assign done = (state == DONE);
  assign a    = busy & vec_idx[1];
  assign b    = busy & vec_idx[0];

endmodule

// File: doc/gate_sweep_ctrl.md
GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter HOLD, default 5: clock cycles each input vector is held on the gate under test (legal range 1..255).
REQ-002 The block SHALL have parameter CW, default 8: width of the internal hold counter.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a sweep; sampled only in IDLE.
REQ-006 The block SHALL have port y, input, 1 bit: output of the 2-input XOR gate under test.
REQ-007 The block SHALL have ports a and b, each output, 1 bit: drive the inputs of the gate under test.
REQ-008 The block SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse at sweep end.
REQ-010 The block SHALL have port pass, output, 1 bit: result of the last completed sweep (1 = zero mismatches).
REQ-011 The block SHALL have port err_cnt, output, 3 bits: mismatch count of the current or last sweep.
REQ-012 The block SHALL have port vec_idx, output, 2 bits: index of the vector currently applied, or the last one sampled.

Function
REQ-013 The FSM SHALL have states IDLE, APPLY and DONE; {a,b} SHALL equal vec_idx in APPLY and SHALL be 0 in IDLE and DONE.
REQ-014 In IDLE with start=1 at edge k, the block SHALL enter APPLY with vec_idx=0, hold count=0, err_cnt=0 and busy=1 from cycle k+1.
REQ-015 In APPLY, the hold counter SHALL increment each cycle; at count HOLD-1 the block SHALL sample y and compare it with a^b.
REQ-016 On a mismatch at that sample, err_cnt SHALL increment by 1; with 4 vectors the maximum is 4, so no saturation is needed.
REQ-017 After the sample, if vec_idx<3 the block SHALL increment vec_idx and clear the counter; if vec_idx=3 it SHALL enter DONE with vec_idx held at 3.
REQ-018 Each vector SHALL be presented for exactly HOLD cycles; busy SHALL be high for exactly 4*HOLD cycles; done SHALL be high in cycle k+4*HOLD+1.
REQ-019 In DONE, busy SHALL be 0, done SHALL be 1 and pass SHALL load (err_cnt==0); the next state SHALL unconditionally be IDLE.
REQ-020 start SHALL be ignored in APPLY and DONE; start held high SHALL relaunch a sweep in the IDLE cycle following DONE.
REQ-021 pass, err_cnt and vec_idx SHALL hold their values in IDLE until the next accepted start.
REQ-022 pass SHALL be unchanged while busy=1.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, a=b=0, busy=0, done=0, pass=0, err_cnt=0, vec_idx=0 and hold count=0, independent of clk.
REQ-024 A reset in mid-sweep SHALL abort the sweep with no done pulse; the first start after rst_n rises SHALL behave per REQ-014.

Configuration
REQ-025 With macro SWEEP_ERR_HALT_EN defined, the first mismatch SHALL send the FSM directly to DONE, with vec_idx held at the failing vector, err_cnt=1 and pass=0.
REQ-026 With SWEEP_ERR_HALT_EN undefined, all 4 vectors SHALL always be applied, per REQ-017.

Verification
REQ-027 HOLD=5, correct XOR, start pulse -> {a,b} steps 00,01,10,11 at 5 cycles each, done at cycle k+21, pass=1, err_cnt=0.
REQ-028 HOLD=5, y stuck at 0 -> err_cnt=2 (vectors 1 and 2), pass=0, done at cycle k+21.
REQ-029 HOLD=5, DUT is XNOR; run once without and once with SWEEP_ERR_HALT_EN -> without: err_cnt=4; with: done at cycle k+6, vec_idx=0, err_cnt=1.
REQ-030 HOLD=5, start re-pulsed at cycle k+7, then rst_n low at cycle k+12 -> restart ignored; after reset all outputs are 0, no done pulse, busy=0.
REQ-031 HOLD=1, start held high -> a sweep every 6 cycles (4 APPLY, 1 DONE, 1 IDLE), done period 6, pass=1.
